ife_scan_ctrl: RTL and testbench

IFE_SCAN_CTRL -- requirements
Module: ife_scan_ctrl

---
 rtl/ife_pkg.sv | 16 +
 rtl/ife_scan_ctrl_tap.sv | 28 ++
 rtl/ife_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_ife_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ife_pkg.sv
// Shared constants and state encoding for the image scan controller.
// Exports: IMG_W_DEF, AW, RES_TMO_DEF, state_t.
package ife_pkg;
  localparam int IMG_W_DEF   = 128;
  localparam int AW          = 14;
  localparam int RES_TMO_DEF = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPT,
    S_EVAL,
    S_WAIT,
    S_WRITE
  } state_t;
endpackage

// File: rtl/ife_scan_ctrl_tap.sv
// ife_tap_addr: combinational 3x3 tap address and pad flag generator.
// Ports: x, y (pixel), k (tap 0..8) -> iaddr (0 when padded), pad.
module ife_tap_addr
  import ife_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF
) (
  input  logic [AW-1:0] x,
  input  logic [AW-1:0] y,
  input  logic [3:0]    k,
  output logic [AW-1:0] iaddr,
  output logic          pad
);
  logic [1:0] row;
  logic [1:0] col;
  int         xi;
  int         yi;

  always_comb begin
    row   = 2'(k / 4'd3);
    col   = 2'(k % 4'd3);
    xi    = int'(x) + int'(col) - 1;
    yi    = int'(y) + int'(row) - 1;
    pad   = (xi < 0) || (xi >= IMG_W) ||
            (yi < 0) || (yi >= IMG_W);
    iaddr = pad ? '0 : AW'(yi * IMG_W + xi);
  end
endmodule

// File: rtl/ife_scan_ctrl.sv
// ife_scan_ctrl: raster scan of a square image, 3x3 window fetch,
// result handshake with timeout, and result memory write per pixel.
// Ports: clk, reset, ready/sel (start), busy, iaddr/idata (source),
// mode/win_data/win_valid (to kernel), res_valid/res_data (from kernel),
// addr/data_wr/wen (result memory), tmo_err (sticky per frame).
module ife_scan_ctrl
  import ife_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int RES_TMO = RES_TMO_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic [1:0]    sel,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [7:0]    idata,
  output logic [1:0]    mode,
  output logic [71:0]   win_data,
  output logic          win_valid,
  input  logic          res_valid,
  input  logic [7:0]    res_data,
  output logic [AW-1:0] addr,
  output logic [7:0]    data_wr,
  output logic          wen,
  output logic          tmo_err
);
  localparam int NPIX = IMG_W * IMG_W;
  localparam int TW   = $clog2(RES_TMO + 1);

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] x;
  logic [AW-1:0] y;
  logic [AW-1:0] p;
  logic [3:0]    k;
  logic [TW-1:0] tcnt;
  logic          cap_en;
  logic          cap_pad;
  logic [3:0]    cap_k;
  logic [AW-1:0] tap_addr;
  logic          tap_pad;
  logic          take;
  logic          tmo;
  logic          last;

  ife_tap_addr #(.IMG_W(IMG_W)) u_tap (
    .x    (x),
    .y    (y),
    .k    (k),
    .iaddr(tap_addr),
    .pad  (tap_pad)
  );

  assign busy      = (state != S_IDLE);
  assign win_valid = (state == S_EVAL);
  assign wen       = (state == S_WRITE);
  assign iaddr     = (state == S_FETCH) ? tap_addr : '0;
  assign last      = (p == AW'(NPIX - 1));

  always_comb begin
    state_n = state;
    take    = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      S_IDLE:  if (ready) state_n = S_FETCH;
      S_FETCH: if (k == 4'd8) state_n = S_CAPT;
      S_CAPT:  state_n = S_EVAL;
      S_EVAL: begin
        take    = res_valid;
        state_n = res_valid ? S_WRITE : S_WAIT;
      end
      S_WAIT: begin
        take = res_valid;
        tmo  = !res_valid && (tcnt == TW'(RES_TMO - 1));
        if (take || tmo) state_n = S_WRITE;
      end
      S_WRITE: state_n = last ? S_IDLE : S_FETCH;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      x        <= '0;
      y        <= '0;
      p        <= '0;
      k        <= '0;
      tcnt     <= '0;
      cap_en   <= 1'b0;
      cap_pad  <= 1'b0;
      cap_k    <= '0;
      mode     <= '0;
      win_data <= '0;
      addr     <= '0;
      data_wr  <= '0;
      tmo_err  <= 1'b0;
    end else begin
      state   <= state_n;
      // Source data lags the address by one cycle, so remember
      // which tap was issued and whether it was padding.
      cap_en  <= (state == S_FETCH);
      cap_k   <= k;
      cap_pad <= tap_pad;
      if (cap_en)
        win_data[cap_k*8 +: 8] <= cap_pad ? 8'h00 : idata;
      unique case (state)
        S_IDLE: begin
          if (ready) begin
            mode    <= sel;
            p       <= '0;
            x       <= '0;
            y       <= '0;
            k       <= '0;
            tmo_err <= 1'b0;
          end
        end
        S_FETCH: k <= (k == 4'd8) ? 4'd0 : k + 4'd1;
        S_EVAL:  tcnt <= '0;
        S_WAIT:  tcnt <= tcnt + 1'b1;
        S_WRITE: begin
          p <= p + 1'b1;
          if (x == AW'(IMG_W - 1)) begin
            x <= '0;
            y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
        default: ;
      endcase
      if (take || tmo) begin
        addr    <= p;
        data_wr <= take ? res_data : 8'h00;
      end
      if (tmo) tmo_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ife_scan_ctrl.sv
// Self-checking bench for ife_scan_ctrl on a 32x32 image.
// Random image and kernel latency checked against a behavioural model.
module tb_ife_scan_ctrl;
  import ife_pkg::*;

  localparam int W   = 32;
  localparam int N   = W * W;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ready = 1'b0;
  logic [1:0]    sel = 2'd0;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [7:0]    idata;
  logic [1:0]    mode;
  logic [71:0]   win_data;
  logic          win_valid;
  logic          res_valid;
  logic [7:0]    res_data;
  logic [AW-1:0] addr;
  logic [7:0]    data_wr;
  logic          wen;
  logic          tmo_err;

  ife_scan_ctrl #(.IMG_W(W), .RES_TMO(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .sel      (sel),
    .busy     (busy),
    .iaddr    (iaddr),
    .idata    (idata),
    .mode     (mode),
    .win_data (win_data),
    .win_valid(win_valid),
    .res_valid(res_valid),
    .res_data (res_data),
    .addr     (addr),
    .data_wr  (data_wr),
    .wen      (wen),
    .tmo_err  (tmo_err)
  );

  always #5 clk = ~clk;

  logic [7:0] pat [N];

  always @(posedge clk) idata <= pat[iaddr];

  int   n_cmp = 0;
  int   n_err = 0;
  int   pix_idx = 0;
  int   wr_cnt = 0;
  int   busy_cnt = 0;
  int   max_ia = 0;
  int   tmo_pix = -1;
  logic [7:0] xmask = 8'h00;
  bit   rnd_lat = 0;
  bit   garb = 0;
  bit   pending = 0;
  int   lat = 0;
  int   dl = 0;
  int   exp_lat = 0;

  task automatic chk(input string tag, input logic [71:0] act,
                     input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [71:0] ref_win(input int pi);
    logic [71:0] v;
    int px, py, xx, yy;
    v  = '0;
    px = pi % W;
    py = pi / W;
    for (int t = 0; t < 9; t++) begin
      xx = px + t % 3 - 1;
      yy = py + t / 3 - 1;
      if (xx >= 0 && xx < W && yy >= 0 && yy < W)
        v[8*t +: 8] = pat[yy*W + xx];
    end
    return v;
  endfunction

  function automatic logic [7:0] exp_res(input int pi);
    if (pi == tmo_pix) return 8'h00;
    return pat[pi] ^ xmask;
  endfunction

  // Kernel datapath model and result-memory monitor.
  initial begin
    string tg;
    res_valid = 1'b0;
    res_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (int'(iaddr) > max_ia) max_ia = int'(iaddr);
      if (pending) lat++;
      if (wen) begin
        chk("wr_addr", addr, pix_idx);
        chk("wr_data", data_wr, exp_res(pix_idx));
        chk("wr_lat", lat, exp_lat);
        chk("wr_tmo_err", tmo_err,
            tmo_pix >= 0 && pix_idx >= tmo_pix);
        pix_idx++;
        wr_cnt++;
        pending = 0;
      end
      if (win_valid) begin
        tg = (pix_idx == 0) ? "win_p0" :
             (pix_idx == N-1) ? "win_plast" : "win";
        chk(tg, win_data, ref_win(pix_idx));
        pending = 1;
        lat = 0;
        dl = rnd_lat ? int'($urandom_range(0, 4)) : 0;
        if (pix_idx == tmo_pix) dl = 1000;
        exp_lat = (pix_idx == tmo_pix) ? TMO + 1 : dl + 1;
      end
      if (pending) begin
        res_valid = (lat == dl);
        res_data  = exp_res(pix_idx);
      end else begin
        res_valid = garb ? 1'($urandom) : 1'b0;
        res_data  = 8'($urandom);
      end
    end
  end

  task automatic reset_check(input string t);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_wen"}, wen, 0);
    chk({t, "_winv"}, win_valid, 0);
    chk({t, "_tmo"}, tmo_err, 0);
    chk({t, "_mode"}, mode, 0);
    chk({t, "_iaddr"}, iaddr, 0);
    chk({t, "_addr"}, addr, 0);
    chk({t, "_dwr"}, data_wr, 0);
    chk({t, "_win"}, win_data, 0);
  endtask

  task automatic fill_pat();
    for (int i = 0; i < N; i++) pat[i] = 8'($urandom);
    pat[0] = 8'hA5;
  endtask

  task automatic start(input logic [1:0] s, input int hold);
    pix_idx  = 0;
    wr_cnt   = 0;
    busy_cnt = 0;
    max_ia   = 0;
    pending  = 0;
    chk("idle_busy", busy, 0);
    ready = 1'b1;
    sel   = s;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        chk("busy_rise", busy, 1);
        chk("mode_latch", mode, s);
      end
    end
    ready = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (busy && c < 30000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("frame_done", busy, 0);
  endtask

  initial begin
    int c;
    logic [1:0] s;
    repeat (3) @(posedge clk);
    #1;
    reset_check("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame A: zero-wait echo of the centre tap, sel changes after start.
    fill_pat();
    tmo_pix = -1; xmask = 8'h00; rnd_lat = 0; garb = 0;
    start(2'd3, 3);
    sel = 2'd0;
    repeat (40) @(posedge clk);
    #1;
    chk("mode_hold", mode, 3);
    wait_done();
    chk("a_wr_cnt", wr_cnt, N);
    chk("a_busy_cyc", busy_cnt, 12 * N);
    chk("a_iaddr_max", max_ia < N, 1);
    chk("a_tmo_err", tmo_err, 0);

    // Frame B: random latency, stray strobes, one withheld result.
    fill_pat();
    s = 2'($urandom_range(1, 3));
    tmo_pix = 200; xmask = {6'd0, s}; rnd_lat = 1; garb = 1;
    start(s, 1);
    wait_done();
    chk("b_wr_cnt", wr_cnt, N);
    chk("b_tmo_sticky", tmo_err, 1);
    chk("b_iaddr_max", max_ia < N, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("b_tmo_idle", tmo_err, 1);

    // Frame C: reset mid-frame while fetching pixel 500.
    tmo_pix = 10; xmask = 8'h02; rnd_lat = 0; garb = 0;
    start(2'd2, 1);
    c = 0;
    while (wr_cnt < 500 && c < 20000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("c_reach_500", wr_cnt, 500);
    repeat (3) @(posedge clk);
    #1;
    chk("c_tmo_pre", tmo_err, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset_check("mid_rst");
    reset = 1'b0;
    pending = 0;
    pix_idx = 0;
    wr_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("c_no_wr", wr_cnt, 0);
    chk("c_idle", busy, 0);

    // Frame D: fresh start after reset writes from address 0.
    fill_pat();
    tmo_pix = -1; xmask = 8'h00; rnd_lat = 0; garb = 0;
    start(2'd1, 1);
    wait_done();
    chk("d_wr_cnt", wr_cnt, N);
    chk("d_busy_cyc", busy_cnt, 12 * N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
